// File: rtl/heart_bit_pkg.sv
// Shared encodings for the multi-channel heart-bit blinker.
package heart_bit_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_STROBE = 2'd2;
  localparam logic [1:0] MODE_DOUBLE = 2'd3;

  typedef enum logic [1:0] {PhOn1, PhGap, PhOn2, PhRest} dbl_phase_e;

  localparam int unsigned REST_MULT = 3;

endpackage

// File: rtl/heart_bit_channel.sv
// One heart-bit channel: stored config, half-period counter, pattern phase, out and beat.
module heart_bit_channel
  import heart_bit_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = 50_000_000,
  parameter int unsigned DEFAULT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             hold_restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] half,
  input  logic [1:0]       mode,
  output logic             out,
  output logic             beat
);

  logic [CNT_W-1:0] half_q, half_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tog_q, tog_d;
  dbl_phase_e       dph_q, dph_d;
  logic [1:0]       sub_q, sub_d;
  logic             start_q, start_d;
  logic             out_q, out_d;
  logic             beat_q, beat_d;
  logic             tc;

  assign tc = (cnt_q == half_q - CNT_W'(1));

  always_comb begin
    half_d  = half_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    dph_d   = dph_q;
    sub_d   = sub_q;
    start_d = start_q;
    out_d   = out_q;
    beat_d  = 1'b0;
    if (wr || hold_restart) begin
      if (wr) begin
        half_d = (half == '0) ? CNT_W'(1) : half;
        mode_d = mode;
      end
      cnt_d   = '0;
      tog_d   = 1'b0;
      dph_d   = PhOn1;
      sub_d   = 2'd0;
      start_d = 1'b1;
      out_d   = 1'b0;
    end else if (run) begin
      if (mode_q == MODE_DOUBLE && start_q) begin
        // First active cycle after a restart is spent entering ON1.
        start_d = 1'b0;
        out_d   = 1'b1;
        beat_d  = 1'b1;
      end else begin
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        unique case (mode_q)
          MODE_OFF: out_d = 1'b0;
          MODE_BLINK: begin
            if (tc) begin
              tog_d  = ~tog_q;
              out_d  = ~tog_q;
              beat_d = ~tog_q;
            end
          end
          MODE_STROBE: begin
            out_d  = tc & tog_q;
            beat_d = tc & tog_q;
            if (tc) tog_d = ~tog_q;
          end
          MODE_DOUBLE: begin
            if (tc) begin
              unique case (dph_q)
                PhOn1: begin
                  dph_d = PhGap;
                  out_d = 1'b0;
                end
                PhGap: begin
                  dph_d = PhOn2;
                  out_d = 1'b1;
                end
                PhOn2: begin
                  dph_d = PhRest;
                  sub_d = 2'd0;
                  out_d = 1'b0;
                end
                PhRest: begin
                  if (sub_q == 2'(REST_MULT - 1)) begin
                    dph_d  = PhOn1;
                    out_d  = 1'b1;
                    beat_d = 1'b1;
                  end else begin
                    sub_d = sub_q + 2'd1;
                  end
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_q  <= CNT_W'(DEFAULT_HALF);
      mode_q  <= 2'(DEFAULT_MODE);
      cnt_q   <= '0;
      tog_q   <= 1'b0;
      dph_q   <= PhOn1;
      sub_q   <= 2'd0;
      start_q <= 1'b1;
      out_q   <= 1'b0;
      beat_q  <= 1'b0;
    end else begin
      half_q  <= half_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      dph_q   <= dph_d;
      sub_q   <= sub_d;
      start_q <= start_d;
      out_q   <= out_d;
      beat_q  <= beat_d;
    end
  end

  assign out  = out_q;
  assign beat = beat_q;

endmodule

// File: rtl/heart_bit_multi.sv
// Multi-channel heart-bit blinker: lock-qualified run control and config write decode.
module heart_bit_multi
  import heart_bit_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = 50_000_000,
  parameter int unsigned DEFAULT_MODE = 1,
  localparam int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             locked,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [1:0]       cfg_mode,
  output logic [N_CH-1:0]  heart_bit_out,
  output logic [N_CH-1:0]  beat
);

  logic            run;
  logic            hold_restart;
  logic [N_CH-1:0] wr;

  assign run          = enable & locked;
  assign hold_restart = ~locked;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Out-of-range channel numbers match no decode and are dropped.
    assign wr[i] = cfg_we && (cfg_ch == CH_W'(i));

    heart_bit_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF),
      .DEFAULT_MODE (DEFAULT_MODE)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .hold_restart (hold_restart),
      .wr           (wr[i]),
      .half         (cfg_half),
      .mode         (cfg_mode),
      .out          (heart_bit_out[i]),
      .beat         (beat[i])
    );
  end

endmodule

// File: tb/tb_heart_bit_multi.sv
// Randomised and directed check of heart_bit_multi against an active-cycle-count model.
module tb_heart_bit_multi;

  localparam int unsigned N_CH  = 5;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned DEF_H = 4;
  localparam int unsigned CH_W  = $clog2(N_CH);

  logic             clk = 1'b0;
  logic             rst, enable, locked, cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic [1:0]       cfg_mode;
  logic [N_CH-1:0]  heart_bit_out, beat;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: per channel, the number of active cycles since the last restart.
  int unsigned m_h    [N_CH];
  logic [1:0]  m_mode [N_CH];
  int unsigned m_n    [N_CH];
  logic        m_out  [N_CH];
  logic        m_beat [N_CH];

  heart_bit_multi #(
    .N_CH         (N_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DEF_H),
    .DEFAULT_MODE (1)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .locked        (locked),
    .cfg_we        (cfg_we),
    .cfg_ch        (cfg_ch),
    .cfg_half      (cfg_half),
    .cfg_mode      (cfg_mode),
    .heart_bit_out (heart_bit_out),
    .beat          (beat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int unsigned h, p;
    for (int c = 0; c < N_CH; c++) begin
      m_beat[c] = 1'b0;
      if (rst) begin
        m_h[c] = DEF_H; m_mode[c] = 2'd1; m_n[c] = 0; m_out[c] = 1'b0;
      end else if (cfg_we && (int'(cfg_ch) == c)) begin
        m_h[c]    = (cfg_half == 0) ? 1 : int'(cfg_half);
        m_mode[c] = cfg_mode;
        m_n[c]    = 0;
        m_out[c]  = 1'b0;
      end else if (!locked) begin
        m_n[c] = 0; m_out[c] = 1'b0;
      end else if (enable) begin
        m_n[c]++;
        h = m_h[c];
        case (m_mode[c])
          2'd0: m_out[c] = 1'b0;
          2'd1: begin
            m_out[c]  = ((m_n[c] / h) % 2) == 1;
            m_beat[c] = (m_n[c] % (2 * h)) == h;
          end
          2'd2: begin
            m_out[c]  = (m_n[c] % (2 * h)) == 0;
            m_beat[c] = m_out[c];
          end
          default: begin
            p = (m_n[c] - 1) % (6 * h);
            m_out[c]  = (p < h) || (p >= 2 * h && p < 3 * h);
            m_beat[c] = (p == 0);
          end
        endcase
      end
    end
  endtask

  task automatic step(input string tag);
    logic [N_CH-1:0] eo, eb;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < N_CH; c++) begin
      eo[c] = m_out[c];
      eb[c] = m_beat[c];
    end
    check_eq({tag, ".out"}, 32'(heart_bit_out), 32'(eo));
    check_eq({tag, ".beat"}, 32'(beat), 32'(eb));
  endtask

  task automatic write_cfg(input int ch, input int h, input int md, input string tag);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_half = CNT_W'(h); cfg_mode = 2'(md);
    step(tag);
    cfg_we = 1'b0;
  endtask

  task automatic run_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    bit hit;
    rst = 1'b1; enable = 1'b1; locked = 1'b1; cfg_we = 1'b0;
    cfg_ch = '0; cfg_half = '0; cfg_mode = 2'd0;
    #1;
    run_steps(2, "reset");
    rst = 1'b0;
    run_steps(16, "default_blink");

    write_cfg(1, 2, 2, "wr_strobe");
    run_steps(12, "strobe");
    write_cfg(2, 1, 3, "wr_double");
    run_steps(14, "double");

    run_steps(2, "pre_freeze");
    enable = 1'b0;
    run_steps(5, "freeze");
    enable = 1'b1;
    run_steps(10, "resume");

    locked = 1'b0;
    run_steps(3, "unlocked");
    locked = 1'b1;
    run_steps(12, "relock");

    write_cfg(3, 0, 1, "wr_half0");
    run_steps(8, "half0");
    write_cfg(N_CH, 3, 0, "wr_bad_ch");
    run_steps(8, "bad_ch");

    // Step until ch0 sits on its terminal count, then write it there.
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (m_n[0] % m_h[0] == m_h[0] - 1) hit = 1'b1;
      else step("seek_tc");
    end
    check_eq("tc_reached", 32'(hit), 32'd1);
    write_cfg(0, 4, 1, "wr_at_tc");
    run_steps(10, "after_tc_wr");

    rst = 1'b1;
    write_cfg(1, 3, 3, "rst_with_wr");
    rst = 1'b0;
    run_steps(12, "post_rst");

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      enable   = ($urandom_range(0, 7) != 0);
      locked   = ($urandom_range(0, 24) != 0);
      cfg_we   = ($urandom_range(0, 11) == 0);
      cfg_ch   = CH_W'($urandom_range(0, (1 << CH_W) - 1));
      cfg_half = CNT_W'($urandom_range(0, 5));
      cfg_mode = 2'($urandom_range(0, 3));
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/heart_bit_multi.md
Name: heart_bit_multi

Overview:
- Parametrised, multi-channel successor to the single heart-bit LED blinker; sits after the PLL in FPGA bring-up tops.
- N_CH independent channels, each with a runtime-programmable half-period and a pattern mode (off, blink, strobe, double-beat "lub-dub").
- Counting is qualified by the PLL lock indicator, so patterns start cleanly once the clock is stable.

Parameters:
- N_CH, 4, number of output channels (1..16)
- CNT_W, 32, half-period counter width
- DEFAULT_HALF, 50_000_000, reset half-period in clk cycles (0.5 s at 100 MHz)
- DEFAULT_MODE, 1, reset mode for all channels (BLINK)

Ports:
- clk  in  1  system clock (PLL output)
- rst  in  1  synchronous, active-high reset
- enable  in  1  global run; low freezes all channels
- locked  in  1  PLL lock; low holds all channels in restart
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel
- cfg_half  in  CNT_W  new half-period, H
- cfg_mode  in  2  new mode
- heart_bit_out  out  N_CH  pattern outputs, registered
- beat  out  N_CH  one-cycle pulse at the start of each pattern period

Behaviour:
- Reset: heart_bit_out=0, beat=0, every channel H=DEFAULT_HALF, mode=DEFAULT_MODE, phase=start, counter=0.
- Active cycle means enable=1 and locked=1. Counter runs 0..H-1 over active cycles. Terminal count (TC) is reached at H-1, then counter returns to 0 and the phase advances.
- Effective H = max(cfg_half, 1). H=1 advances the phase every active cycle.
- Modes:
  - 0 OFF: output is 0 and beat is 0.
  - 1 BLINK: output toggles at each TC. Period = 2H.
  - 2 STROBE: output=1 for exactly one cycle at the TC that ends every second phase. Period = 2H.
  - 3 DOUBLE: FSM ON1(H, out=1) -> GAP(H, out=0) -> ON2(H, out=1) -> REST(3H, out=0) -> ON1. Period = 6H. REST uses an internal 2-bit sub-counter, 3 passes of H.
- Restart state: BLINK and STROBE start low with the counter at 0. DOUBLE starts in ON1 with out=1 on the first active cycle.
- beat pulses in the cycle the channel enters its period-start phase: BLINK on the 0->1 toggle, STROBE coincident with the strobe, DOUBLE on entry to ON1 (including the first entry after restart).
- All outputs are registered. Output changes are visible on the cycle after the TC edge.
- enable=0: counter, phase and outputs hold their values. beat is forced to 0.
- locked=0: channel forced to restart state, outputs 0, beat 0. Stored config is retained. On locked rising, counting begins in that cycle.
- cfg_we=1 with cfg_ch<N_CH:
  - H and mode are stored at the clock edge, and that channel restarts next cycle.
  - The write is applied even if enable=0 or locked=0.
  - Other channels are unaffected.
- cfg_we with cfg_ch>=N_CH is ignored with no side effects.
- rst has priority over cfg_we and locked. A write in the same cycle as rst is discarded.
- A write arriving at the TC cycle wins: restart, no phase advance.

Decomposition:
- Package heart_bit_pkg holds:
  - mode encoding: MODE_OFF=0, MODE_BLINK=1, MODE_STROBE=2, MODE_DOUBLE=3
  - DOUBLE phase enum (ON1, GAP, ON2, REST)
  - REST_MULT=3
- Sub-module heart_bit_channel: one channel's config registers, counter, FSM, out and beat. Ports are clk, rst, run, hold_restart, wr, half, mode, out, beat.
- The top instantiates N_CH channels in a generate loop and decodes cfg_ch into per-channel wr.

Test Plan:
- Reset defaults with DEFAULT_HALF=4, all channels BLINK, enable=1, locked=1 -> each out is low for cycles 0-3 and high for cycles 4-7, beat at cycle 4. Repeats every 8 cycles.
- Write ch1 H=2, mode STROBE -> ch1 out=1 for one cycle every 4 cycles, beat coincident. Channels 0, 2 and 3 are undisturbed.
- Write ch2 H=1, mode DOUBLE -> ch2 out sequence 1,0,1,0,0,0 repeating (period 6), beat on every ON1 entry.
- enable low for 5 cycles mid-phase -> ch0 counter and out frozen, beat never asserted. Resumes the remaining count exactly.
- locked low for 3 cycles -> all outs 0, beat 0. After locked rises, BLINK channels are low for H cycles and a DOUBLE channel is high immediately.
- Boundary cases:
  - cfg_half=0 -> behaves as H=1.
  - cfg_ch=N_CH -> no change.
  - Write at a TC cycle -> restart with no toggle.
  - rst concurrent with a write -> defaults.
